rect_sum_responder: RTL and testbench

//  Responder end of the rectangle-sum query interface used by the Haar feature calculator.

---
 rtl/rect_sum_responder.sv | 198 +++++++++++++++++++
 tb/tb_rect_sum_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_sum_responder.sv
// Rectangle-sum responder: reads up to four integral-image corners and returns
// D - B - C + A (modulo 2**SUM_WIDTH) for an inclusive rectangle query.
module rect_sum_responder #(
   parameter int SUM_WIDTH  = 24,
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           query_x1,
   input  logic [15:0]           query_y1,
   input  logic [15:0]           query_x2,
   input  logic [15:0]           query_y2,
   input  logic                  query_valid,
   output logic [SUM_WIDTH-1:0]  rect_sum,
   output logic                  rect_sum_valid,
   output logic                  query_err,
   output logic                  busy,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [SUM_WIDTH-1:0]  mem_rdata
);

   // state | meaning
   // IDLE  | waiting for query_valid, coordinates latched on accept
   // CHECK | legality check; issues slot D when legal
   // READ  | issues slots B, C, A (k = 1..3)
   // DRAIN | final two capture edges, then publish the sum
   // RESP  | response held until query_valid is sampled low
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam logic [15:0]           IMG_W16 = 16'(IMG_WIDTH);
   localparam logic [15:0]           IMG_H16 = 16'(IMG_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_WIDTH);

   state_t                state_q, state_d;
   logic [15:0]           x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
   logic [1:0]            k_q, k_d;
   logic [SUM_WIDTH-1:0]  acc_q, acc_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  iss_sub_q, iss_sub_d;
   logic                  cap_vld_q, cap_vld_d;
   logic                  cap_sub_q, cap_sub_d;
   logic [SUM_WIDTH-1:0]  sum_q, sum_d;
   logic                  sum_vld_q, sum_vld_d;
   logic                  err_q, err_d;

   logic [1:0]            slot;
   logic                  slot_skip;
   logic                  slot_sub;
   logic [15:0]           slot_x, slot_y;
   logic [ADDR_WIDTH-1:0] slot_addr;
   logic                  illegal;
   logic [SUM_WIDTH-1:0]  acc_nxt;

   // Slot encoding: bit0 selects x1-1 (B, A), bit1 selects y1-1 (C, A).
   always_comb begin
      slot      = (state_q == CHECK) ? 2'd0 : k_q;
      slot_skip = (slot[0] && (x1_q == 16'd0)) || (slot[1] && (y1_q == 16'd0));
      slot_sub  = slot[0] ^ slot[1];
      slot_x    = slot[0] ? (x1_q - 16'd1) : x2_q;
      slot_y    = slot[1] ? (y1_q - 16'd1) : y2_q;
      slot_addr = ADDR_WIDTH'(slot_y) * IMG_W_A + ADDR_WIDTH'(slot_x);
      illegal   = (x2_q < x1_q) || (y2_q < y1_q) || (x2_q >= IMG_W16) || (y2_q >= IMG_H16);
      if (cap_vld_q)
         acc_nxt = cap_sub_q ? (acc_q - mem_rdata) : (acc_q + mem_rdata);
      else
         acc_nxt = acc_q;
   end

   always_comb begin
      state_d   = state_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      x2_d      = x2_q;
      y2_d      = y2_q;
      k_d       = k_q;
      acc_d     = acc_nxt;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      iss_sub_d = 1'b0;
      cap_vld_d = rd_en_q;
      cap_sub_d = iss_sub_q;
      sum_d     = sum_q;
      sum_vld_d = sum_vld_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (query_valid) begin
               x1_d    = query_x1;
               y1_d    = query_y1;
               x2_d    = query_x2;
               y2_d    = query_y2;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (illegal) begin
               sum_d     = '0;
               err_d     = 1'b1;
               sum_vld_d = 1'b1;
               state_d   = RESP;
            end else begin
               acc_d     = '0;
               rd_en_d   = 1'b1;
               addr_d    = slot_addr;
               iss_sub_d = 1'b0;
               k_d       = 2'd1;
               state_d   = READ;
            end
         end
         READ: begin
            rd_en_d   = !slot_skip;
            iss_sub_d = slot_sub && !slot_skip;
            if (!slot_skip)
               addr_d = slot_addr;
            if (k_q == 2'd3) begin
               k_d     = 2'd0;
               state_d = DRAIN;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         DRAIN: begin
            if (k_q == 2'd1) begin
               sum_d     = acc_nxt;
               sum_vld_d = 1'b1;
               err_d     = 1'b0;
               k_d       = 2'd0;
               state_d   = RESP;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         RESP: begin
            if (!query_valid) begin
               sum_vld_d = 1'b0;
               err_d     = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         x1_q      <= '0;
         y1_q      <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         iss_sub_q <= 1'b0;
         cap_vld_q <= 1'b0;
         cap_sub_q <= 1'b0;
         sum_q     <= '0;
         sum_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         iss_sub_q <= iss_sub_d;
         cap_vld_q <= cap_vld_d;
         cap_sub_q <= cap_sub_d;
         sum_q     <= sum_d;
         sum_vld_q <= sum_vld_d;
         err_q     <= err_d;
      end
   end

   assign rect_sum       = sum_q;
   assign rect_sum_valid = sum_vld_q;
   assign query_err      = err_q;
   assign busy           = (state_q != IDLE);
   assign mem_rd_en      = rd_en_q;
   assign mem_addr       = addr_q;

endmodule

// File: tb/tb_rect_sum_responder.sv
// Bench for rect_sum_responder: RAM model with one-cycle read latency and a
// corner-lookup reference model of the rectangle sum.
module tb_rect_sum_responder;

   localparam int W = 160;
   localparam int H = 120;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] query_x1 = '0, query_y1 = '0, query_x2 = '0, query_y2 = '0;
   logic        query_valid = 1'b0;
   logic [23:0] rect_sum;
   logic        rect_sum_valid, query_err, busy, mem_rd_en;
   logic [14:0] mem_addr;
   logic [23:0] mem_rdata = '0;

   logic [23:0] ram [0:W*H-1];
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_rd = 0;
   int          rd_addrs[$];

   rect_sum_responder dut (
      .clk(clk), .rst_n(rst_n),
      .query_x1(query_x1), .query_y1(query_y1), .query_x2(query_x2), .query_y2(query_y2),
      .query_valid(query_valid),
      .rect_sum(rect_sum), .rect_sum_valid(rect_sum_valid), .query_err(query_err), .busy(busy),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM: data for an address presented in one cycle appears in the next; junk otherwise.
   always @(posedge clk) begin
      if (mem_rd_en && (int'(mem_addr) < W*H))
         mem_rdata <= ram[mem_addr];
      else
         mem_rdata <= 24'($urandom);
   end

   always @(negedge clk) begin
      if (mem_rd_en) begin
         n_rd++;
         rd_addrs.push_back(int'(mem_addr));
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [23:0] ii(input int x, input int y);
      if (x < 0 || y < 0) return 24'd0;
      return ram[y*W + x];
   endfunction

   task automatic fill_ones();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            ram[y*W + x] = 24'((x+1)*(y+1));
   endtask

   task automatic do_query(input int x1, input int y1, input int x2, input int y2,
                           input bit early, output logic [23:0] got);
      logic [23:0] exp_sum;
      bit          bad;
      int          exp_rd, rd0, lat, dur;
      bad = (x2 < x1) || (y2 < y1) || (x2 >= W) || (y2 >= H);
      exp_sum = bad ? 24'd0 : ii(x2, y2) - ii(x1-1, y2) - ii(x2, y1-1) + ii(x1-1, y1-1);
      exp_rd  = bad ? 0 : (1 + int'(x1 > 0)) * (1 + int'(y1 > 0));
      @(posedge clk); #1;
      query_x1 = 16'(x1); query_y1 = 16'(y1); query_x2 = 16'(x2); query_y2 = 16'(y2);
      query_valid = 1'b1;
      rd0 = n_rd;
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      while (!rect_sum_valid && lat < 20) begin
         @(negedge clk);
         lat++;
         if (early && lat == 1) query_valid = 1'b0;
      end
      chk("latency", 32'(lat), bad ? 32'd1 : 32'd6);
      chk("rect_sum", 32'(rect_sum), 32'(exp_sum));
      chk("query_err", 32'(query_err), 32'(bad));
      chk("read_count", 32'(n_rd - rd0), 32'(exp_rd));
      if (!bad && n_rd > rd0)
         chk("first_addr_D", 32'(rd_addrs[rd0]), 32'(y2*W + x2));
      got = rect_sum;
      dur = 0;
      if (rect_sum_valid) begin
         dur = 1;
         if (!early) begin
            @(posedge clk); #1;
            query_valid = 1'b0;
         end
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rect_sum_valid) dur++;
            else break;
         end
      end
      query_valid = 1'b0;
      chk("valid_duration", 32'(dur), early ? 32'd1 : 32'd2);
      chk("sum_holds", 32'(rect_sum), 32'(exp_sum));
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [23:0] r;
      fill_ones();
      #1;
      chk("rst_sum", 32'(rect_sum), 32'd0);
      chk("rst_valid", 32'(rect_sum_valid), 32'd0);
      chk("rst_err", 32'(query_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      do_query(2, 3, 5, 7, 1'b0, r);
      chk("t1_const", 32'(r), 32'd20);
      do_query(0, 0, 0, 0, 1'b0, r);
      chk("t2_const", 32'(r), 32'd1);
      chk("t2_addr0", 32'(rd_addrs[rd_addrs.size()-1]), 32'd0);
      do_query(0, 0, 159, 119, 1'b0, r);
      chk("t3_full", 32'(r), 32'd19200);
      do_query(0, 5, 159, 5, 1'b0, r);
      chk("t3_row", 32'(r), 32'd160);
      do_query(5, 2, 4, 9, 1'b0, r);
      do_query(3, 3, 160, 9, 1'b0, r);
      do_query(1, 1, 1, 119, 1'b0, r);
      do_query(2, 0, 2, 120, 1'b0, r);

      ram[3*W+3] = 24'h000004;
      ram[3*W+0] = 24'hFFFFFE;
      ram[0*W+3] = 24'hFFFFFF;
      ram[0]     = 24'hFFFFFD;
      do_query(1, 1, 3, 3, 1'b0, r);
      chk("t5_wrap", 32'(r), 32'h000004);
      fill_ones();

      // Reset in READ: accept at E0, then hit reset between E2 and E3.
      @(posedge clk); #1;
      query_x1 = 16'd2; query_y1 = 16'd3; query_x2 = 16'd5; query_y2 = 16'd7;
      query_valid = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("midrst_addr", 32'(mem_addr), 32'd0);
      chk("midrst_sum", 32'(rect_sum), 32'd0);
      chk("midrst_valid", 32'(rect_sum_valid), 32'd0);
      query_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rect_sum_valid || busy) seen++;
         end
         chk("midrst_no_resp", 32'(seen), 32'd0);
      end
      do_query(1, 1, 2, 2, 1'b0, r);
      chk("t6_const", 32'(r), 32'd4);

      for (int i = 0; i < W*H; i++) ram[i] = 24'($urandom);
      for (int n = 0; n < 40; n++) begin
         int x1, y1, x2, y2;
         bit e;
         x1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, W-1));
         y1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, H-1));
         x2 = int'($urandom_range(x1, W-1));
         y2 = int'($urandom_range(y1, H-1));
         e  = 1'b0;
         case ($urandom_range(0, 9))
            0: begin int t; t = x1; x1 = x2 + 1; x2 = t; end
            1: x2 = W + int'($urandom_range(0, 200));
            2: y2 = H + int'($urandom_range(0, 200));
            3: e = 1'b1;
            default: ;
         endcase
         if (x1 > 65535) x1 = 65535;
         do_query(x1, y1, x2, y2, e, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
